// File: rtl/conf_port_arbiter_pkg.sv
// Shared widths, option-count limits and FSM encoding for the CONF port arbiter.
// DATA_W is six BCD digits; N_OPT follows the highest MENU index.
package conf_port_arbiter_pkg;

  localparam int UNIT_BCD_W     = 6;
  localparam int MENU_INDEX_MAX = 4;
  localparam int DATA_W         = UNIT_BCD_W * 4;
  localparam int IDX_W          = 3;
  localparam int N_OPT          = MENU_INDEX_MAX + 1;

  localparam logic [IDX_W-1:0] N_OPT_IDX = IDX_W'(N_OPT);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HOLD = 3'd1,
    ST_WAIT = 3'd2,
    ST_XFER = 3'd3,
    ST_DONE = 3'd4
  } arb_state_t;

  function automatic logic idx_in_range(input logic [IDX_W-1:0] idx);
    return (idx < N_OPT_IDX);
  endfunction

endpackage

// File: rtl/conf_port_arbiter_rr_pick.sv
// Two-way round-robin picker: chooses which requester is granted from IDLE.
// When both request, the one not granted last wins.
module conf_rr_pick (
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last,
  output logic o_any,
  output logic o_pick
);

  // Grant selection; o_pick is the requester index.
  always_comb begin
    o_any  = i_req0 | i_req1;
    o_pick = 1'b0;
    if (i_req0 && i_req1) begin
      o_pick = ~i_last;
    end else if (i_req1) begin
      o_pick = 1'b1;
    end else begin
      o_pick = 1'b0;
    end
  end

endmodule

// File: rtl/conf_port_arbiter.sv
// Arbitrates the single CONF option port between the MENU front-end (0) and an
// auxiliary config loader (1), with locked sessions and one-cycle-latency access sequencing.
module conf_port_arbiter
  import conf_port_arbiter_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_ce,
  input  logic              i_req0,
  input  logic              i_req1,
  input  logic              i_stb0,
  input  logic              i_stb1,
  input  logic              i_we0,
  input  logic              i_we1,
  input  logic [IDX_W-1:0]  i_idx0,
  input  logic [IDX_W-1:0]  i_idx1,
  input  logic [DATA_W-1:0] i_wdata0,
  input  logic [DATA_W-1:0] i_wdata1,
  output logic              o_gnt0,
  output logic              o_gnt1,
  output logic              o_ack0,
  output logic              o_ack1,
  output logic              o_err0,
  output logic              o_err1,
  output logic [DATA_W-1:0] o_rdata0,
  output logic [DATA_W-1:0] o_rdata1,
  output logic [IDX_W-1:0]  o_conf_selected_index,
  input  logic [DATA_W-1:0] i_conf_selected_value,
  output logic [DATA_W-1:0] o_conf_selected_new_value,
  output logic              o_conf_selected_set
);

  arb_state_t        r_state;
  logic              r_owner;
  logic              r_last;
  logic              r_gnt0;
  logic              r_gnt1;
  logic              r_ack0;
  logic              r_ack1;
  logic              r_err0;
  logic              r_err1;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;
  logic              r_we;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_new_value;
  logic              r_set;

  logic              w_pick_any;
  logic              w_pick;
  logic              w_own_req;
  logic              w_own_stb;
  logic              w_own_we;
  logic [IDX_W-1:0]  w_own_idx;
  logic [DATA_W-1:0] w_own_wdata;
  logic              w_idx_ok;
  logic [DATA_W-1:0] w_rd_value;

  conf_rr_pick u_rr_pick (
    .i_req0 (i_req0),
    .i_req1 (i_req1),
    .i_last (r_last),
    .o_any  (w_pick_any),
    .o_pick (w_pick)
  );

  // Only the current owner's strobe and fields are ever looked at.
  assign w_own_req   = r_owner ? i_req1   : i_req0;
  assign w_own_stb   = r_owner ? i_stb1   : i_stb0;
  assign w_own_we    = r_owner ? i_we1    : i_we0;
  assign w_own_idx   = r_owner ? i_idx1   : i_idx0;
  assign w_own_wdata = r_owner ? i_wdata1 : i_wdata0;
  assign w_idx_ok    = idx_in_range(r_idx);
  assign w_rd_value  = w_idx_ok ? i_conf_selected_value : {DATA_W{1'b0}};

  // Arbitration FSM and access datapath; pulses clear on the next enabled cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_owner     <= 1'b0;
      r_last      <= 1'b1;
      r_gnt0      <= 1'b0;
      r_gnt1      <= 1'b0;
      r_ack0      <= 1'b0;
      r_ack1      <= 1'b0;
      r_err0      <= 1'b0;
      r_err1      <= 1'b0;
      r_rdata0    <= {DATA_W{1'b0}};
      r_rdata1    <= {DATA_W{1'b0}};
      r_we        <= 1'b0;
      r_idx       <= {IDX_W{1'b0}};
      r_wdata     <= {DATA_W{1'b0}};
      r_new_value <= {DATA_W{1'b0}};
      r_set       <= 1'b0;
    end else if (i_ce) begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      r_err0 <= 1'b0;
      r_err1 <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pick_any) begin
            r_owner <= w_pick;
            r_gnt0  <= ~w_pick;
            r_gnt1  <= w_pick;
            r_state <= ST_HOLD;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_HOLD: begin
          // A strobe wins over a simultaneous release so the session ends cleanly.
          if (w_own_stb) begin
            r_we    <= w_own_we;
            r_idx   <= w_own_idx;
            r_wdata <= w_own_wdata;
            r_state <= ST_WAIT;
          end else if (!w_own_req) begin
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_last  <= r_owner;
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_HOLD;
          end
        end
        ST_WAIT: begin
          r_state <= ST_XFER;
        end
        ST_XFER: begin
          if (w_idx_ok && r_we) begin
            r_new_value <= r_wdata;
            r_set       <= 1'b1;
          end else begin
            r_set       <= 1'b0;
          end
          if (r_owner) begin
            r_rdata1 <= w_rd_value;
            r_ack1   <= 1'b1;
            r_err1   <= ~w_idx_ok;
          end else begin
            r_rdata0 <= w_rd_value;
            r_ack0   <= 1'b1;
            r_err0   <= ~w_idx_ok;
          end
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_set   <= 1'b0;
          r_state <= ST_HOLD;
        end
        default: begin
          r_gnt0  <= 1'b0;
          r_gnt1  <= 1'b0;
          r_set   <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end else begin
      r_state <= r_state;
    end
  end

  assign o_gnt0                    = r_gnt0;
  assign o_gnt1                    = r_gnt1;
  assign o_ack0                    = r_ack0;
  assign o_ack1                    = r_ack1;
  assign o_err0                    = r_err0;
  assign o_err1                    = r_err1;
  assign o_rdata0                  = r_rdata0;
  assign o_rdata1                  = r_rdata1;
  assign o_conf_selected_index     = r_idx;
  assign o_conf_selected_new_value = r_new_value;
  assign o_conf_selected_set       = r_set;

endmodule

// File: tb/tb_conf_port_arbiter.sv
// Self-checking bench for conf_port_arbiter: scenario tasks plus a scoreboard
// of expected read data / error flags popped on every ack.
module tb_conf_port_arbiter;
  import conf_port_arbiter_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, ce = 1'b0;
  logic req0 = 1'b0, req1 = 1'b0, stb0 = 1'b0, stb1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [2:0]  idx0 = 3'd0, idx1 = 3'd0;
  logic [23:0] wdata0 = 24'h0, wdata1 = 24'h0;
  logic gnt0, gnt1, ack0, ack1, err0, err1, conf_set;
  logic [23:0] rdata0, rdata1, conf_new_value;
  logic [23:0] conf_value = 24'h0;
  logic [2:0]  conf_index;

  conf_port_arbiter dut (
    .i_clk(clk), .i_rst(rst), .i_ce(ce),
    .i_req0(req0), .i_req1(req1), .i_stb0(stb0), .i_stb1(stb1),
    .i_we0(we0), .i_we1(we1), .i_idx0(idx0), .i_idx1(idx1),
    .i_wdata0(wdata0), .i_wdata1(wdata1),
    .o_gnt0(gnt0), .o_gnt1(gnt1), .o_ack0(ack0), .o_ack1(ack1),
    .o_err0(err0), .o_err1(err1), .o_rdata0(rdata0), .o_rdata1(rdata1),
    .o_conf_selected_index(conf_index), .i_conf_selected_value(conf_value),
    .o_conf_selected_new_value(conf_new_value), .o_conf_selected_set(conf_set)
  );

  // CONF option store: registered read (one ce cycle latency), written on set.
  logic [23:0] conf_mem  [0:4] = '{24'h000010, 24'h000300, 24'h000150, 24'h000777, 24'h001234};
  logic [23:0] model_mem [0:4] = '{24'h000010, 24'h000300, 24'h000150, 24'h000777, 24'h001234};

  always @(posedge clk) begin
    if (ce) begin
      conf_value <= (conf_index < 3'd5) ? conf_mem[conf_index] : 24'h0;
      if (conf_set && conf_index < 3'd5) conf_mem[conf_index] <= conf_new_value;
    end
  end

  typedef struct { logic who; logic [23:0] rdata; logic err; } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int n_tests = 0, n_fail = 0;
  int set_cnt = 0, ack1_cnt = 0;
  logic [23:0] last_nv = 24'h0;
  logic [2:0]  last_si = 3'd0;
  bit mon_en = 1'b0;

  // Scoreboard consumer and set/grant monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (mon_en && ce && !rst) begin
      if (ack0 || ack1) begin
        n_tests++;
        if (ack1) ack1_cnt++;
        if (ack0 && ack1) begin
          n_fail++; $display("FAIL ack_both: ack0=%0b ack1=%0b, required one", ack0, ack1);
        end else if (sb.size() == 0) begin
          n_fail++; $display("FAIL spurious_ack: ack0=%0b ack1=%0b, required none", ack0, ack1);
        end else begin
          mon_e = sb.pop_front();
          if (ack1 !== mon_e.who || (ack1 ? rdata1 : rdata0) !== mon_e.rdata ||
              (ack1 ? err1 : err0) !== mon_e.err) begin
            n_fail++;
            $display("FAIL sb_ack: who=%0b rdata=%h err=%0b, required who=%0b rdata=%h err=%0b",
                     ack1, ack1 ? rdata1 : rdata0, ack1 ? err1 : err0,
                     mon_e.who, mon_e.rdata, mon_e.err);
          end
        end
      end
      if (conf_set) begin
        set_cnt++; last_nv = conf_new_value; last_si = conf_index;
      end
      if (gnt0 || gnt1) begin
        n_tests++;
        if (gnt0 && gnt1) begin
          n_fail++; $display("FAIL gnt_exclusive: gnt0=1 gnt1=1, required at most one");
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_exp(input logic who, input logic we, input logic [2:0] idx, input logic [23:0] wd);
    exp_t e;
    e.who = who;
    if (idx < 3'd5) begin
      e.rdata = model_mem[idx]; e.err = 1'b0;
      if (we) model_mem[idx] = wd;
    end else begin
      e.rdata = 24'h0; e.err = 1'b1;
    end
    sb.push_back(e);
  endtask

  task automatic drive_stb(input logic who, input logic we, input logic [2:0] idx, input logic [23:0] wd);
    if (who) begin stb1 = 1'b1; we1 = we; idx1 = idx; wdata1 = wd; end
    else     begin stb0 = 1'b1; we0 = we; idx0 = idx; wdata0 = wd; end
  endtask

  task automatic clear_stb();
    stb0 = 1'b0; stb1 = 1'b0;
  endtask

  task automatic access(input logic who, input logic we, input logic [2:0] idx, input logic [23:0] wd);
    int lat;
    push_exp(who, we, idx, wd);
    drive_stb(who, we, idx, wd);
    tick();
    clear_stb();
    lat = 1;
    while (!(who ? ack1 : ack0) && lat < 12) begin tick(); lat++; end
    n_tests++;
    if (lat !== 3) begin n_fail++; $display("FAIL access_latency: %0d ce cycles, required 3", lat); end
    tick();
    n_tests++;
    if ((who ? ack1 : ack0) !== 1'b0) begin
      n_fail++; $display("FAIL ack_pulse_width: ack still %0b, required 0", who ? ack1 : ack0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ce = 1'b0;
    tick(); tick();
    n_tests++;
    if ({gnt0, gnt1, ack0, ack1, err0, err1, conf_set} !== 7'b0 || conf_index !== 3'd0 ||
        conf_new_value !== 24'h0 || rdata0 !== 24'h0 || rdata1 !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_state: flags=%b idx=%0d nv=%h rd0=%h rd1=%h, required all zero",
               {gnt0, gnt1, ack0, ack1, err0, err1, conf_set}, conf_index, conf_new_value, rdata0, rdata1);
    end
    rst = 1'b0; ce = 1'b1; mon_en = 1'b1;
  endtask

  task automatic test_grant();
    req0 = 1'b1;
    n_tests++;
    if (gnt0 !== 1'b0) begin n_fail++; $display("FAIL grant_early: gnt0=%0b, required 0", gnt0); end
    tick();
    n_tests++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
      n_fail++; $display("FAIL grant0: gnt0=%0b gnt1=%0b, required 1 0", gnt0, gnt1);
    end
  endtask

  task automatic test_read();
    int s = set_cnt;
    access(1'b0, 1'b0, 3'd2, 24'h0);
    n_tests++;
    if (set_cnt !== s) begin n_fail++; $display("FAIL read_no_set: %0d set pulses, required 0", set_cnt - s); end
  endtask

  task automatic test_write();
    int s = set_cnt;
    access(1'b0, 1'b1, 3'd1, 24'h000450);
    n_tests++;
    if (set_cnt !== s + 1 || last_nv !== 24'h000450 || last_si !== 3'd1) begin
      n_fail++;
      $display("FAIL write_set: pulses=%0d nv=%h idx=%0d, required 1 000450 1", set_cnt - s, last_nv, last_si);
    end
    n_tests++;
    if (conf_index !== 3'd1) begin n_fail++; $display("FAIL write_index: %0d, required 1", conf_index); end
    access(1'b0, 1'b0, 3'd1, 24'h0);
  endtask

  task automatic test_error();
    int s = set_cnt;
    access(1'b0, 1'b1, 3'd6, 24'h000999);
    n_tests++;
    if (set_cnt !== s) begin n_fail++; $display("FAIL err_no_set: %0d set pulses, required 0", set_cnt - s); end
  endtask

  task automatic test_nonowner();
    int s = set_cnt;
    int a = ack1_cnt;
    logic [2:0] ib = conf_index;
    drive_stb(1'b1, 1'b1, 3'd0, 24'h000555);
    tick();
    clear_stb();
    for (int i = 0; i < 6; i++) tick();
    n_tests++;
    if (set_cnt !== s || ack1_cnt !== a || conf_index !== ib || gnt1 !== 1'b0) begin
      n_fail++;
      $display("FAIL nonowner_ignored: sets=%0d acks=%0d idx=%0d gnt1=%0b, required 0 0 %0d 0",
               set_cnt - s, ack1_cnt - a, conf_index, gnt1, ib);
    end
  endtask

  task automatic test_back_to_back();
    access(1'b0, 1'b0, 3'd3, 24'h0);
    access(1'b0, 1'b1, 3'd4, 24'h004321);
    access(1'b0, 1'b0, 3'd4, 24'h0);
    req0 = 1'b0;
    tick();
    n_tests++;
    if (gnt0 !== 1'b0) begin n_fail++; $display("FAIL release0: gnt0=%0b, required 0", gnt0); end
  endtask

  task automatic test_round_robin();
    rst = 1'b1; tick(); rst = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    tick();
    n_tests++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
      n_fail++; $display("FAIL rr_first: gnt0=%0b gnt1=%0b, required 1 0", gnt0, gnt1);
    end
    req0 = 1'b0;
    tick();
    n_tests++;
    if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
      n_fail++; $display("FAIL rr_release: gnt0=%0b gnt1=%0b, required 0 0", gnt0, gnt1);
    end
    tick();
    n_tests++;
    if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
      n_fail++; $display("FAIL rr_handover: gnt0=%0b gnt1=%0b, required 0 1", gnt0, gnt1);
    end
    access(1'b1, 1'b0, 3'd2, 24'h0);
    req1 = 1'b0;
    tick();
    req0 = 1'b1; req1 = 1'b1;
    tick();
    n_tests++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
      n_fail++; $display("FAIL rr_fairness: gnt0=%0b gnt1=%0b, required 1 0", gnt0, gnt1);
    end
    req1 = 1'b0;
  endtask

  task automatic test_ce_stall();
    int s = set_cnt;
    int n;
    push_exp(1'b0, 1'b1, 3'd0, 24'h000042);
    drive_stb(1'b0, 1'b1, 3'd0, 24'h000042);
    tick();
    clear_stb();
    ce = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_tests++;
      if (conf_index !== 3'd0 || conf_set !== 1'b0 || ack0 !== 1'b0) begin
        n_fail++; $display("FAIL ce_freeze: idx=%0d set=%0b ack=%0b, required 0 0 0", conf_index, conf_set, ack0);
      end
    end
    ce = 1'b1;
    n = 1;
    while (!ack0 && n < 12) begin tick(); n++; end
    n_tests++;
    if (n !== 3) begin n_fail++; $display("FAIL ce_latency: %0d ce cycles, required 3", n); end
    tick();
    n_tests++;
    if (set_cnt !== s + 1 || last_nv !== 24'h000042) begin
      n_fail++; $display("FAIL ce_write: pulses=%0d nv=%h, required 1 000042", set_cnt - s, last_nv);
    end
  endtask

  task automatic test_reset_mid();
    drive_stb(1'b0, 1'b1, 3'd3, 24'h000888);
    tick();
    clear_stb();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if (conf_set !== 1'b0 || gnt0 !== 1'b0 || ack0 !== 1'b0 || conf_index !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_mid: set=%0b gnt0=%0b ack0=%0b idx=%0d, required 0 0 0 0", conf_set, gnt0, ack0, conf_index);
    end
    tick();
    n_tests++;
    if (gnt0 !== 1'b1) begin n_fail++; $display("FAIL regrant: gnt0=%0b, required 1", gnt0); end
    access(1'b0, 1'b0, 3'd3, 24'h0);
  endtask

  initial begin
    test_reset();
    test_grant();
    test_read();
    test_write();
    test_error();
    test_nonowner();
    test_back_to_back();
    test_round_robin();
    test_ce_stall();
    test_reset_mid();
    for (int i = 0; i < 4; i++) tick();
    n_tests++;
    if (sb.size() !== 0) begin n_fail++; $display("FAIL sb_drain: %0d entries left, required 0", sb.size()); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
